// File: rtl/thread_reorder_buf.sv
// Reorders out-of-order sha256 core results back into round-robin thread order.
// Optional protocol checking is enabled with `define THREAD_REORDER_CHECK_EN.
module thread_reorder_buf #(
   parameter int N_CORES       = 3,
   parameter int N_CORES_MSB   = (N_CORES > 1) ? $clog2(N_CORES) - 1 : 0,
   parameter int N_THREADS     = 2 * N_CORES,
   parameter int N_THREADS_MSB = N_CORES_MSB + 1,
   parameter int WIDTH         = 32
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     in_wr_en,
   input  logic [N_THREADS_MSB:0]   in_thread_num,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_empty,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         out_data,
   output logic [N_THREADS_MSB:0]   out_thread_num,
   output logic                     err
);

   localparam int TW = N_THREADS_MSB + 1;
   localparam int CW = N_CORES_MSB + 1;
   localparam logic [CW-1:0] LAST_CORE = CW'(N_CORES - 1);
   localparam logic [CW:0]   N_CORES_X = (CW + 1)'(N_CORES);

   logic [WIDTH-1:0]     slot_data_q [N_THREADS];
   logic [N_THREADS-1:0] slot_vld_q, slot_vld_d;
   logic [TW-1:0]        exp_ptr_q, exp_ptr_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic [TW-1:0]        out_tag_q, out_tag_d;
   logic                 out_empty_q, out_empty_d;
   logic                 wr_in_range, wr_ok, load;

   // Load decision uses the pre-write valid bit, so a same-cycle write never feeds the load.
   assign load        = slot_vld_q[exp_ptr_q] && (out_empty_q || rd_en);
   assign wr_in_range = ({1'b0, in_thread_num[TW-1:1]} < N_CORES_X);

`ifdef THREAD_REORDER_CHECK_EN
   logic err_q, err_d, wr_busy;

   // A slot being drained this cycle may legally take the next-lap word.
   assign wr_busy = wr_in_range && slot_vld_q[in_thread_num]
                    && !(load && (in_thread_num == exp_ptr_q));
   assign wr_ok   = in_wr_en && wr_in_range && !wr_busy;
   assign err_d   = err_q | (in_wr_en && (!wr_in_range || wr_busy));

   always_ff @(posedge CLK) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   assign wr_ok = in_wr_en && wr_in_range;
   assign err   = 1'b0;
`endif

   always_comb begin
      exp_ptr_d = exp_ptr_q;
      if (load) begin
         if (exp_ptr_q[TW-1:1] == LAST_CORE) exp_ptr_d = {{CW{1'b0}}, ~exp_ptr_q[0]};
         else exp_ptr_d = {exp_ptr_q[TW-1:1] + CW'(1), exp_ptr_q[0]};
      end
   end

   always_comb begin
      slot_vld_d = slot_vld_q;
      if (load)  slot_vld_d[exp_ptr_q]     = 1'b0;
      if (wr_ok) slot_vld_d[in_thread_num] = 1'b1;
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      out_empty_d = out_empty_q;
      if (load) begin
         out_data_d  = slot_data_q[exp_ptr_q];
         out_tag_d   = exp_ptr_q;
         out_empty_d = 1'b0;
      end else if (rd_en) begin
         out_empty_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         slot_vld_q  <= '0;
         exp_ptr_q   <= '0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         out_empty_q <= 1'b1;
      end else begin
         slot_vld_q  <= slot_vld_d;
         exp_ptr_q   <= exp_ptr_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_empty_q <= out_empty_d;
      end
   end

   // Slot payload needs no reset; the valid bits gate every use of it.
   always_ff @(posedge CLK) begin
      if (wr_ok) slot_data_q[in_thread_num] <= in_data;
   end

   assign out_empty      = out_empty_q;
   assign out_data       = out_data_q;
   assign out_thread_num = out_tag_q;

endmodule

// File: tb/tb_thread_reorder_buf.sv
// Directed self-checking bench for thread_reorder_buf (N_CORES=3, WIDTH=32).
// Error expectations follow THREAD_REORDER_CHECK_EN as compiled.
module tb_thread_reorder_buf;

   logic        CLK = 1'b0;
   logic        reset, in_wr_en, rd_en;
   logic [2:0]  in_thread_num;
   logic [31:0] in_data;
   logic        out_empty, err;
   logic [31:0] out_data;
   logic [2:0]  out_thread_num;

   int checks   = 0;
   int failures = 0;

   localparam int ORDER [6] = '{0, 2, 4, 1, 3, 5};

`ifdef THREAD_REORDER_CHECK_EN
   localparam logic        EXP_ERR = 1'b1;
   localparam logic [31:0] EXP_W4  = 32'hD0;
`else
   localparam logic        EXP_ERR = 1'b0;
   localparam logic [31:0] EXP_W4  = 32'hD1;
`endif

   thread_reorder_buf dut (
      .CLK(CLK), .reset(reset), .in_wr_en(in_wr_en), .in_thread_num(in_thread_num),
      .in_data(in_data), .out_empty(out_empty), .rd_en(rd_en), .out_data(out_data),
      .out_thread_num(out_thread_num), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs;
      in_wr_en = 1'b0; rd_en = 1'b0; in_thread_num = '0; in_data = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic write_set(input int tag, input logic [31:0] d);
      in_wr_en = 1'b1; in_thread_num = 3'(tag); in_data = d;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if (out_empty !== 1'b1 || out_data !== 32'h0 || out_thread_num !== 3'd0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: got empty=%b data=%h tag=%0d err=%b want empty=1 data=0 tag=0 err=0",
                  out_empty, out_data, out_thread_num, err);
      end
      tick();
      checks++;
      if (out_empty !== 1'b1) begin
         failures++; $display("FAIL reset_idle_empty: got %b want 1", out_empty);
      end
   endtask

   task automatic test_in_order;
      do_reset();
      rd_en = 1'b1;
      write_set(0, 32'hA0);
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (j == 1) begin
            checks++;
            if (out_empty !== 1'b1) begin
               failures++; $display("FAIL inorder_latency: got empty=%b want 1 one cycle after write", out_empty);
            end
         end else if (j <= 7) begin
            checks++;
            if (out_empty !== 1'b0 || out_thread_num !== 3'(ORDER[j-2]) || out_data !== 32'hA0 + 32'(j-2)) begin
               failures++;
               $display("FAIL inorder_word%0d: got empty=%b tag=%0d data=%h want empty=0 tag=%0d data=%h",
                        j-2, out_empty, out_thread_num, out_data, ORDER[j-2], 32'hA0 + 32'(j-2));
            end
         end else begin
            checks++;
            if (out_empty !== 1'b1) begin
               failures++; $display("FAIL inorder_drain: got empty=%b want 1", out_empty);
            end
         end
         if (j < 6) write_set(ORDER[j], 32'hA0 + 32'(j));
         else in_wr_en = 1'b0;
      end
      idle_inputs();
   endtask

   task automatic test_out_of_order;
      do_reset();
      write_set(2, 32'hB2);
      tick();
      checks++;
      if (out_empty !== 1'b1) begin
         failures++; $display("FAIL ooo_tag2_only: got empty=%b want 1", out_empty);
      end
      write_set(0, 32'hB0);
      tick();
      checks++;
      if (out_empty !== 1'b1) begin
         failures++; $display("FAIL ooo_before_load: got empty=%b want 1", out_empty);
      end
      in_wr_en = 1'b0;
      tick();
      checks++;
      if (out_empty !== 1'b0 || out_thread_num !== 3'd0 || out_data !== 32'hB0) begin
         failures++;
         $display("FAIL ooo_first: got empty=%b tag=%0d data=%h want empty=0 tag=0 data=b0",
                  out_empty, out_thread_num, out_data);
      end
      tick();
      checks++;
      if (out_empty !== 1'b0 || out_thread_num !== 3'd0 || out_data !== 32'hB0) begin
         failures++;
         $display("FAIL ooo_hold: got empty=%b tag=%0d data=%h want empty=0 tag=0 data=b0",
                  out_empty, out_thread_num, out_data);
      end
      rd_en = 1'b1;
      tick();
      checks++;
      if (out_empty !== 1'b0 || out_thread_num !== 3'd2 || out_data !== 32'hB2) begin
         failures++;
         $display("FAIL ooo_second: got empty=%b tag=%0d data=%h want empty=0 tag=2 data=b2",
                  out_empty, out_thread_num, out_data);
      end
      tick();
      checks++;
      if (out_empty !== 1'b1 || out_data !== 32'hB2) begin
         failures++;
         $display("FAIL ooo_drain: got empty=%b data=%h want empty=1 data=b2", out_empty, out_data);
      end
      idle_inputs();
   endtask

   task automatic test_wrap_backpressure;
      int          n_wr, n_taken, cyc;
      logic        prev_rd, prev_empty;
      logic [31:0] prev_data;
      logic [2:0]  prev_tag;
      n_wr = 0; n_taken = 0; cyc = 0;
      do_reset();
      while (n_taken < 14 && cyc < 200) begin
         // Only write a slot once its previous-lap word has left through the output.
         if (n_wr < 14 && n_wr < n_taken + 5) begin
            write_set(ORDER[n_wr % 6], 32'hC0 + 32'(n_wr));
            n_wr++;
         end else begin
            in_wr_en = 1'b0;
         end
         rd_en = cyc[0];
         if (rd_en && !out_empty) begin
            checks++;
            if (out_thread_num !== 3'(ORDER[n_taken % 6]) || out_data !== 32'hC0 + 32'(n_taken)) begin
               failures++;
               $display("FAIL wrap_word%0d: got tag=%0d data=%h want tag=%0d data=%h",
                        n_taken, out_thread_num, out_data, ORDER[n_taken % 6], 32'hC0 + 32'(n_taken));
            end
            n_taken++;
         end
         prev_rd = rd_en; prev_empty = out_empty; prev_data = out_data; prev_tag = out_thread_num;
         tick();
         cyc++;
         if (!prev_rd && !prev_empty) begin
            checks++;
            if (out_empty !== 1'b0 || out_data !== prev_data || out_thread_num !== prev_tag) begin
               failures++;
               $display("FAIL wrap_hold: got empty=%b tag=%0d data=%h want empty=0 tag=%0d data=%h",
                        out_empty, out_thread_num, out_data, prev_tag, prev_data);
            end
         end
      end
      checks++;
      if (n_taken != 14) begin
         failures++; $display("FAIL wrap_timeout: got %0d words want 14", n_taken);
      end
      idle_inputs();
      tick();
      checks++;
      if (out_empty !== 1'b1) begin
         failures++; $display("FAIL wrap_drain: got empty=%b want 1", out_empty);
      end
   endtask

   task automatic test_same_slot;
      int          n;
      int          exp_tag [6];
      logic [31:0] exp_dat [6];
      exp_tag = '{2, 4, 1, 3, 5, 0};
      exp_dat = '{32'h1002, 32'h1004, 32'h1001, 32'h1003, 32'h1005, 32'h61};
      n = 0;
      do_reset();
      write_set(0, 32'h60);
      tick();
      write_set(0, 32'h61);
      tick();
      checks++;
      if (out_empty !== 1'b0 || out_thread_num !== 3'd0 || out_data !== 32'h60) begin
         failures++;
         $display("FAIL same_slot_old: got empty=%b tag=%0d data=%h want empty=0 tag=0 data=60",
                  out_empty, out_thread_num, out_data);
      end
      rd_en = 1'b1;
      for (int j = 0; j < 20; j++) begin
         if (j < 5) write_set(exp_tag[j], exp_dat[j]);
         else in_wr_en = 1'b0;
         tick();
         if (!out_empty) begin
            checks++;
            if (n >= 6) begin
               failures++;
               $display("FAIL same_slot_extra: got tag=%0d data=%h want no word", out_thread_num, out_data);
            end else if (out_thread_num !== 3'(exp_tag[n]) || out_data !== exp_dat[n]) begin
               failures++;
               $display("FAIL same_slot_word%0d: got tag=%0d data=%h want tag=%0d data=%h",
                        n, out_thread_num, out_data, exp_tag[n], exp_dat[n]);
            end
            n++;
         end
      end
      checks++;
      if (n != 6) begin
         failures++; $display("FAIL same_slot_count: got %0d words want 6", n);
      end
      idle_inputs();
   endtask

   task automatic test_error;
      int          n;
      int          exp_tag [3];
      logic [31:0] exp_dat [3];
      exp_tag = '{0, 2, 4};
      exp_dat = '{32'hE0, 32'hE2, EXP_W4};
      n = 0;
      do_reset();
      write_set(4, 32'hD0);
      tick();
      write_set(4, 32'hD1);
      tick();
      in_wr_en = 1'b0;
      tick();
      checks++;
      if (err !== EXP_ERR) begin
         failures++; $display("FAIL err_overwrite: got err=%b want %b", err, EXP_ERR);
      end
      write_set(0, 32'hE0);
      tick();
      write_set(2, 32'hE2);
      rd_en = 1'b1;
      for (int j = 0; j < 12; j++) begin
         tick();
         in_wr_en = 1'b0;
         if (!out_empty && n < 3) begin
            checks++;
            if (out_thread_num !== 3'(exp_tag[n]) || out_data !== exp_dat[n]) begin
               failures++;
               $display("FAIL err_word%0d: got tag=%0d data=%h want tag=%0d data=%h",
                        n, out_thread_num, out_data, exp_tag[n], exp_dat[n]);
            end
            n++;
         end
      end
      checks++;
      if (n != 3) begin
         failures++; $display("FAIL err_word_count: got %0d words want 3", n);
      end
      do_reset();
      write_set(6, 32'hEE);
      tick();
      in_wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      checks++;
      if (err !== EXP_ERR) begin
         failures++; $display("FAIL err_range: got err=%b want %b", err, EXP_ERR);
      end
      tick();
      tick();
      checks++;
      if (out_empty !== 1'b1) begin
         failures++; $display("FAIL err_range_dropped: got empty=%b tag=%0d want empty=1", out_empty, out_thread_num);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid;
      do_reset();
      for (int j = 0; j < 4; j++) begin
         write_set(ORDER[j], 32'h50 + 32'(j));
         tick();
      end
      in_wr_en = 1'b0;
      tick();
      checks++;
      if (out_empty !== 1'b0 || out_thread_num !== 3'd0 || out_data !== 32'h50) begin
         failures++;
         $display("FAIL mid_before: got empty=%b tag=%0d data=%h want empty=0 tag=0 data=50",
                  out_empty, out_thread_num, out_data);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (out_empty !== 1'b1 || err !== 1'b0 || out_data !== 32'h0 || out_thread_num !== 3'd0) begin
         failures++;
         $display("FAIL mid_reset: got empty=%b err=%b data=%h tag=%0d want empty=1 err=0 data=0 tag=0",
                  out_empty, err, out_data, out_thread_num);
      end
      write_set(0, 32'h77);
      tick();
      in_wr_en = 1'b0;
      checks++;
      if (out_empty !== 1'b1) begin
         failures++; $display("FAIL mid_latency1: got empty=%b want 1", out_empty);
      end
      tick();
      checks++;
      if (out_empty !== 1'b0 || out_thread_num !== 3'd0 || out_data !== 32'h77) begin
         failures++;
         $display("FAIL mid_after: got empty=%b tag=%0d data=%h want empty=0 tag=0 data=77",
                  out_empty, out_thread_num, out_data);
      end
      rd_en = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (out_empty !== 1'b1) begin
         failures++;
         $display("FAIL mid_discarded: got empty=%b tag=%0d data=%h want empty=1",
                  out_empty, out_thread_num, out_data);
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_in_order();
      test_out_of_order();
      test_wrap_backpressure();
      test_same_slot();
      test_error();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/thread_reorder_buf.md
# thread_reorder_buf

Collects per-thread results that sha256 engine cores return out of order, tagged with a thread number {core_num, seq_num}. Releases them strictly in the engine's round-robin thread order: core 0..N_CORES-1 with seq 0, then the same cores with seq 1, then wrap. It sits at the engine output, between the cores and the result packer. It is the consuming end of the thread numbering that the issue side advances.

## Interface
Parameters:
- N_CORES, 3, number of cores.
- N_CORES_MSB, `MSB(N_CORES-1), core_num MSB.
- N_THREADS, 2*N_CORES, thread slots; two per core.
- N_THREADS_MSB, `MSB(N_THREADS-1), thread number MSB.
- WIDTH, 32, result word width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- in_wr_en  in  1  core presents a result this cycle.
- in_thread_num  in  N_THREADS_MSB+1  tag {core_num, seq_num}; seq_num is the LSB.
- in_data  in  WIDTH  result word.
- out_empty  out  1  output register holds no word.
- rd_en  in  1  consumer takes the output word.
- out_data  out  WIDTH  output word.
- out_thread_num  out  N_THREADS_MSB+1  tag of the output word.
- err  out  1  sticky protocol-error flag.

## Operation
Storage:
- N_THREADS slots, each holding WIDTH data and a valid bit, indexed by thread number.
- Expect pointer (thread number), reset 0.
- Output register: out_data, out_thread_num, out_empty.

Write:
- in_wr_en stores in_data into slot[in_thread_num] and sets its valid bit.

Pointer advance:
- If core_num == N_CORES-1: core_num goes to 0 and seq_num toggles.
- Otherwise: core_num+1, seq_num unchanged.
- With N_CORES=3 the order is 0,2,4,1,3,5,0,…

Load:
- Condition: slot[expect] is valid, and (out_empty==1 or rd_en==1).
- Action: copy slot[expect] into the output register, clear its valid bit, advance expect, drive out_empty=0.

Read:
- rd_en with no load in the same cycle sets out_empty=1.
- rd_en while out_empty==1 is ignored.
- out_data and out_thread_num hold their value while out_empty==1.

Boundary conditions:
- Same-cycle write to slot X and load from slot X: the load uses the old contents, the valid bit ends set, and the new word is queued for the next lap. Applies only when slot X was already valid; otherwise the load does not occur that cycle.
- rd_en and load in the same cycle: the next word replaces the current one with no bubble, and out_empty stays 0.
- Reset mid-operation: all valid bits cleared, expect=0, out_empty=1, err=0, out_data=0, out_thread_num=0. Stored words are discarded.

## Timing
- Reset values: out_empty=1, out_data=0, out_thread_num=0, err=0.
- Write in cycle t to the currently expected slot, output register empty: out_empty=0 and data visible in cycle t+2. Latency is 2 (slot write, then load).
- Sustained throughput is 1 word/cycle when slots are pre-filled and rd_en is held high.
- There is no in-side backpressure. Cores never have more than one result outstanding per thread; violation is flagged, not stalled.

## Configuration
- Macro: THREAD_REORDER_CHECK_EN.
- Defined:
  - err is set (sticky until reset) on a write to a slot whose valid bit is set, unless that slot is being loaded the same cycle.
  - err is set on a write with core_num >= N_CORES; that write is dropped.
  - On overwrite, the stored word is kept and the new word is dropped.
- Undefined:
  - err is tied to 0.
  - An overwrite replaces the stored word.
  - An out-of-range tag is dropped silently.

## Test plan
- In-order: write tags 0,2,4,1,3,5 with data 0xA0..0xA5, rd_en held high → output tags 0,2,4,1,3,5, data 0xA0..0xA5. First word visible 2 cycles after its write.
- Out-of-order: write tag 2 (0xB2), then tag 0 (0xB0) → out 0/0xB0, then 2/0xB2. Nothing appears before tag 0 is written.
- Wrap and backpressure: 14 words in order, rd_en toggled 1/0 → all words out in sequence 0,2,4,1,3,5,0,2,…; out_data stable while rd_en=0; expect returns to 0 after tag 5.
- Error (macro defined): write tag 4 twice with no reads → err=1, first word retained. Write tag 6 → err=1, no output.
- Error (macro undefined): same stimulus → err=0, the second tag-4 word is output.
- Reset mid-run: 3 words stored, 1 in the output register, reset for 1 cycle → out_empty=1, err=0. A subsequent write to tag 0 is output with latency 2.
